parity_checker_stream: RTL and testbench
========================================

Name: parity_checker_stream

Overview:
- Receive-side counterpart to the team's 64-bit parity generator.
- Accepts a stream of 64-bit words, each with its transmitted parity bit, over a valid/ready handshake. Recomputes parity in even or odd mode and forwards the word with a registered error flag.
- Keeps a saturating total-error counter and a consecutive-error alarm state machine that stalls input until software clears it.
- Sits between a link receiver and downstream consumers.

Parameters:
- DATA_WIDTH, 64, data word width in bits.
- ERR_CNT_WIDTH, 16, width of the total-error counter.
- MAX_CONSEC_ERR, 4, consecutive erroneous words that trigger ALARM; legal range 1 to 255.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- dataInput  input  DATA_WIDTH  incoming data word.
- parityInput  input  1  parity bit sent with dataInput.
- oddMode  input  1  0 = even-parity check, 1 = odd-parity check; sampled with each accepted word.
- inValid  input  1  dataInput/parityInput are valid.
- inReady  output  1  block can accept a word this cycle.
- dataOutput  output  DATA_WIDTH  registered forwarded word.
- parityError  output  1  registered error flag for dataOutput.
- outValid  output  1  dataOutput/parityError are valid.
- outReady  input  1  downstream accepts the output word.
- clearErrors  input  1  single-cycle pulse: clears counters and sticky flag, and exits ALARM.
- errorCount  output  ERR_CNT_WIDTH  total errors seen, saturating.
- stickyError  output  1  set by any error; held until clearErrors.
- alarm  output  1  high while the FSM is in ALARM.

Behaviour:
- Reset: on the clk edge with reset=1, every output goes to 0 (inReady=0 during reset), the FSM goes to RUN, and the consecutive-error count goes to 0. reset has priority over every other input.
- Parity rule: let p = XOR-reduce(dataInput) XOR parityInput.
  - Even mode (oddMode=0): error when p=1.
  - Odd mode (oddMode=1): error when p=0.
  - Even mode matches the generator: the even-parity bit equals the XOR-reduction of the data.
- Handshake:
  - inReady = (state==RUN) && (!outValid || outReady); combinational from registered state and outReady.
  - A word is accepted when inValid && inReady.
  - On accept, dataOutput, parityError and outValid=1 are loaded on the next edge. Latency is 1 cycle, with full throughput of 1 word/cycle while outReady=1.
  - outValid falls after an output handshake when no new word is accepted in the same cycle.
  - Outputs are held stable while outValid && !outReady.
- Counters (updated on accept only):
  - Error: errorCount increments, saturating at 2^ERR_CNT_WIDTH-1; stickyError is set; the consecutive count increments, saturating at MAX_CONSEC_ERR.
  - Good word: the consecutive count returns to 0.
- FSM:
  - RUN -> ALARM on the edge where an accepted error brings the consecutive count to MAX_CONSEC_ERR. The word that triggers the alarm is still forwarded.
  - ALARM: inReady=0, alarm=1. A pending output word can still drain.
  - ALARM -> RUN on clearErrors.
- clearErrors:
  - Zeroes errorCount, stickyError and the consecutive count, and moves the FSM to RUN.
  - If an accept happens in the same cycle, the clear wins: the counters and sticky flag are 0 after the edge and the accepted word's error is not counted. The word itself is still forwarded with its correct parityError.
- Reset mid-transfer discards any pending output word.

Optional Feature:
- Macro: PARITY_CHK_DROP_BAD_EN.
- Defined: erroneous words are consumed and counted but not forwarded; outValid is not set for them. inReady is unchanged. parityError is then always 0 whenever outValid=1.
- Undefined: every accepted word is forwarded with its parityError flag, as described in Behaviour.

Test Plan:
- Even pass: after reset, dataInput=64'h0000_0000_0000_0003, parityInput=0, oddMode=0, outReady=1 -> next cycle outValid=1, parityError=0, errorCount=0.
- Even/odd error: 64'h1 with parityInput=0, even mode -> parityError=1, errorCount=1, stickyError=1. Same word and parity in odd mode -> parityError=0.
- Backpressure: outReady=0 for 3 cycles with a word held in the output register -> inReady=0 and dataOutput stable. Then outReady=1 with back-to-back inputs -> one output per cycle, no loss or duplication.
- Alarm: MAX_CONSEC_ERR=4, four consecutive bad words -> alarm=1 and inReady=0 after the 4th; all 4 words are forwarded; errorCount=4. Pulse clearErrors -> alarm=0, errorCount=0, inReady=1.
- Streak reset: 3 bad, 1 good, 3 bad -> alarm stays 0, errorCount=6. With ERR_CNT_WIDTH=2, the count saturates at 3.
- Reset mid-stream while outValid=1 and outReady=0 -> the next cycle has all outputs 0. With PARITY_CHK_DROP_BAD_EN, a bad word produces no outValid and errorCount increments.

Source files
------------

// File: rtl/parity_checker_stream.sv
// Streaming 64-bit parity checker: valid/ready in and out, registered error flag,
// saturating error counter and consecutive-error alarm. Optional: PARITY_CHK_DROP_BAD_EN.
module parity_checker_stream #(
   parameter int DATA_WIDTH     = 64,
   parameter int ERR_CNT_WIDTH  = 16,
   parameter int MAX_CONSEC_ERR = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_WIDTH-1:0]    dataInput,
   input  logic                     parityInput,
   input  logic                     oddMode,
   input  logic                     inValid,
   output logic                     inReady,
   output logic [DATA_WIDTH-1:0]    dataOutput,
   output logic                     parityError,
   output logic                     outValid,
   input  logic                     outReady,
   input  logic                     clearErrors,
   output logic [ERR_CNT_WIDTH-1:0] errorCount,
   output logic                     stickyError,
   output logic                     alarm
);

   typedef enum logic {RUN, ALARM} state_t;

   localparam logic [7:0] ConsecMax  = 8'(MAX_CONSEC_ERR);
   localparam logic [7:0] ConsecLast = 8'(MAX_CONSEC_ERR - 1);

   state_t     state;
   logic [7:0] consecCount;
   logic       accept;
   logic       wordError;

   assign inReady   = !reset && (state == RUN) && (!outValid || outReady);
   assign accept    = inValid && inReady;
   // Odd mode flips the sense: a zero overall XOR is the error there.
   assign wordError = ((^dataInput) ^ parityInput) ^ oddMode;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         consecCount <= '0;
         dataOutput  <= '0;
         parityError <= 1'b0;
         outValid    <= 1'b0;
         errorCount  <= '0;
         stickyError <= 1'b0;
         alarm       <= 1'b0;
      end else begin
         if (accept) begin
`ifdef PARITY_CHK_DROP_BAD_EN
            outValid    <= !wordError;
            parityError <= 1'b0;
            if (!wordError)
               dataOutput <= dataInput;
`else
            outValid    <= 1'b1;
            parityError <= wordError;
            dataOutput  <= dataInput;
`endif
         end else if (outReady) begin
            outValid <= 1'b0;
         end

         // A clear in the same cycle as an accept wins over the accept's counting.
         if (clearErrors) begin
            errorCount  <= '0;
            stickyError <= 1'b0;
            consecCount <= '0;
            state       <= RUN;
            alarm       <= 1'b0;
         end else if (accept) begin
            if (wordError) begin
               if (errorCount != '1)
                  errorCount <= errorCount + 1'b1;
               stickyError <= 1'b1;
               if (consecCount >= ConsecLast) begin
                  consecCount <= ConsecMax;
                  state       <= ALARM;
                  alarm       <= 1'b1;
               end else begin
                  consecCount <= consecCount + 8'd1;
               end
            end else begin
               consecCount <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_parity_checker_stream.sv
// Scoreboard bench for parity_checker_stream: directed plus random stimulus,
// reference model from parity counting rules, monitor pops on output handshakes.
module tb_parity_checker_stream;

   localparam int ERR_W   = 3;
   localparam int MAXC    = 4;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [63:0]      dataInput = '0;
   logic             parityInput = 1'b0;
   logic             oddMode = 1'b0;
   logic             inValid = 1'b0;
   logic             inReady;
   logic [63:0]      dataOutput;
   logic             parityError;
   logic             outValid;
   logic             outReady = 1'b0;
   logic             clearErrors = 1'b0;
   logic [ERR_W-1:0] errorCount;
   logic             stickyError;
   logic             alarm;

   parity_checker_stream #(
      .DATA_WIDTH(64),
      .ERR_CNT_WIDTH(ERR_W),
      .MAX_CONSEC_ERR(MAXC)
   ) dut (
      .clk(clk), .reset(reset), .dataInput(dataInput), .parityInput(parityInput),
      .oddMode(oddMode), .inValid(inValid), .inReady(inReady),
      .dataOutput(dataOutput), .parityError(parityError), .outValid(outValid),
      .outReady(outReady), .clearErrors(clearErrors), .errorCount(errorCount),
      .stickyError(stickyError), .alarm(alarm)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] d;
      logic        e;
   } item_t;

   item_t sb[$];
   int    nVec = 0;
   int    nMis = 0;

   // Reference model state
   int mErr = 0;
   int mStreak = 0;
   bit mSticky = 0;
   bit mAlarm = 0;
   bit mOutValid = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares forwarded words against the scoreboard and checks hold stability.
   bit          prevHold = 0;
   logic [63:0] prevData = '0;
   always @(negedge clk) begin
      item_t it;
      if (reset) begin
         prevHold = 0;
      end else begin
         if (prevHold) begin
            check("holdValid", 64'(outValid), 64'd1);
            check("holdData", dataOutput, prevData);
         end
         if (outValid && outReady) begin
            if (sb.size() == 0) begin
               check("unexpectedOutput", 64'(sb.size()), 64'd1);
            end else begin
               it = sb.pop_front();
               check("dataOutput", dataOutput, it.d);
               check("parityError", 64'(parityError), 64'(it.e));
            end
         end
         prevHold = outValid && !outReady;
         prevData = dataOutput;
      end
   end

   function automatic bit refError(input logic [63:0] d, input bit p, input bit odd);
      int ones = $countones(d) + int'(p);
      return odd ? (ones % 2 == 0) : (ones % 2 == 1);
   endfunction

   // Parity bit that makes a word good in even mode: total count of ones even.
   function automatic bit goodEvenParity(input logic [63:0] d);
      return ($countones(d) % 2) == 1;
   endfunction

   task automatic cycle(input bit v, input logic [63:0] d, input bit p, input bit odd,
                        input bit ordy, input bit clr);
      bit expReady, acc, err, fwd;
      item_t it;
      inValid = v; dataInput = d; parityInput = p; oddMode = odd;
      outReady = ordy; clearErrors = clr;
      @(negedge clk);
      expReady = !mAlarm && (!mOutValid || ordy);
      check("inReady", 64'(inReady), 64'(expReady));
      acc = v && expReady;
      err = refError(d, p, odd);
      fwd = acc;
`ifdef PARITY_CHK_DROP_BAD_EN
      fwd = acc && !err;
`endif
      if (fwd) begin
         it.d = d; it.e = err;
         sb.push_back(it);
      end
      if (acc) mOutValid = fwd;
      else if (ordy) mOutValid = 0;
      if (clr) begin
         mErr = 0; mStreak = 0; mSticky = 0; mAlarm = 0;
      end else if (acc) begin
         if (err) begin
            if (mErr < ERR_MAX) mErr++;
            mSticky = 1;
            if (mStreak < MAXC) mStreak++;
            if (mStreak == MAXC) mAlarm = 1;
         end else begin
            mStreak = 0;
         end
      end
      @(posedge clk); #1;
      check("outValid", 64'(outValid), 64'(mOutValid));
      check("errorCount", 64'(errorCount), 64'(mErr));
      check("stickyError", 64'(stickyError), 64'(mSticky));
      check("alarm", 64'(alarm), 64'(mAlarm));
   endtask

   task automatic doReset(input bit ordy);
      reset = 1; inValid = 0; outReady = ordy; clearErrors = 0;
      @(negedge clk);
      check("inReadyInReset", 64'(inReady), 64'd0);
      @(posedge clk); #1;
      check("rstOutValid", 64'(outValid), 64'd0);
      check("rstDataOutput", dataOutput, 64'd0);
      check("rstParityError", 64'(parityError), 64'd0);
      check("rstErrorCount", 64'(errorCount), 64'd0);
      check("rstSticky", 64'(stickyError), 64'd0);
      check("rstAlarm", 64'(alarm), 64'd0);
      sb.delete();
      mErr = 0; mStreak = 0; mSticky = 0; mAlarm = 0; mOutValid = 0;
      reset = 0;
   endtask

   task automatic goodWord(input bit ordy);
      logic [63:0] d = {$urandom, $urandom};
      cycle(1, d, goodEvenParity(d), 0, ordy, 0);
   endtask

   task automatic badWord(input bit ordy);
      logic [63:0] d = {$urandom, $urandom};
      cycle(1, d, !goodEvenParity(d), 0, ordy, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, 1, 0);
   endtask

   initial begin
      logic [63:0] w;
      doReset(1);

      // Even pass and even/odd error cases
      cycle(1, 64'h3, 0, 0, 1, 0);
      cycle(1, 64'h1, 0, 0, 1, 0);
      cycle(1, 64'h1, 0, 1, 1, 0);
      idle(2);

      // Backpressure then back-to-back drain
      goodWord(0);
      for (int i = 0; i < 3; i++) goodWord(0);
      for (int i = 0; i < 8; i++) goodWord(1);
      idle(2);

      // Alarm after MAXC consecutive errors, blocked input, then clear
      cycle(0, '0, 0, 0, 1, 1);
      for (int i = 0; i < MAXC; i++) badWord(1);
      for (int i = 0; i < 3; i++) badWord(1);
      cycle(0, '0, 0, 0, 1, 1);
      idle(1);

      // Streak broken by a good word, then saturation of the narrow counter
      for (int i = 0; i < 3; i++) badWord(1);
      goodWord(1);
      for (int i = 0; i < 3; i++) badWord(1);
      goodWord(1);
      for (int i = 0; i < 3; i++) badWord(1);
      idle(1);

      // Clear coincident with a bad accept: word forwarded, error not counted
      w = 64'h00F0_0000_0000_0001;
      cycle(1, w, !goodEvenParity(w), 0, 1, 1);
      idle(1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         w = {$urandom, $urandom};
         cycle(($urandom_range(0, 3) != 0), w, 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
      end
      cycle(0, '0, 0, 0, 1, 1);
      idle(2);

      // Reset while a word is held under backpressure
      goodWord(0);
      goodWord(0);
      doReset(0);
      idle(2);

      check("scoreboardEmpty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
